// File: rtl/seg_2of5_scan.sv
// seg_2of5_scan: multiplexed 7-segment scanner for 2-of-5 coded digits.
// Each digit slot lasts DIV clocks. seg/dig are registered one edge behind the
// scan index. A load is captured into shadow registers and reaches seg on the
// second edge after it is sampled.
// Optional build macro: SEG_ERR_STICKY_EN makes err sticky until err_clr.
module seg_2of5_scan #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] code_in,
  input  logic                    err_clr,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig,
  output logic                    err,
  output logic                    frame_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [4:0]    CODE_ZERO  = 5'b00110;
  localparam logic [6:0]    SEG_DASH   = 7'b1000000;

  // Map a 2-of-5 code (E1..E5 = bit 4..0) to segments {g,f,e,d,c,b,a}.
  // The ten valid codes are exactly the ten two-hot patterns, so every
  // other value falls through to the dash.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] pat;
    case (code)
      5'b00110: pat = 7'b0111111; // 0
      5'b00011: pat = 7'b0000110; // 1
      5'b00101: pat = 7'b1011011; // 2
      5'b01001: pat = 7'b1001111; // 3
      5'b01010: pat = 7'b1100110; // 4
      5'b01100: pat = 7'b1101101; // 5
      5'b10001: pat = 7'b1111101; // 6
      5'b10010: pat = 7'b0000111; // 7
      5'b10100: pat = 7'b1111111; // 8
      5'b11000: pat = 7'b1101111; // 9
      default:  pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  // A code is valid when exactly two of its five bits are set.
  function automatic logic two_hot(input logic [4:0] code);
    int ones;
    ones = 0;
    for (int i = 0; i < 5; i++) begin
      ones = ones + int'(code[i]);
    end
    return (ones == 2);
  endfunction

  logic [PW-1:0]                presc;
  logic [IW-1:0]                idx;
  logic                         wrap_pend;
  logic [NUM_DIGITS-1:0]        sel;
  logic [NUM_DIGITS-1:0]        invalid;
  logic [NUM_DIGITS-1:0][4:0]   masked;
  logic [4:0]                   cur_code;
  logic                         any_invalid;
  logic                         slot_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      logic [4:0] code_reg;

      // Shadow register for this digit; reloaded only on load.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          code_reg <= CODE_ZERO;
        end else if (load) begin
          code_reg <= code_in[5*gi +: 5];
        end
      end

      assign sel[gi]     = (idx == IW'(gi));
      assign invalid[gi] = !two_hot(code_reg);
      assign masked[gi]  = sel[gi] ? code_reg : 5'b00000;
    end
  endgenerate

  // Pick the shadow code of the digit currently being scanned.
  always_comb begin
    cur_code = 5'b00000;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      cur_code = cur_code | masked[k];
    end
  end

  assign any_invalid = |invalid;
  assign slot_end    = (presc == PRESC_LAST);

  // Prescaler and digit index; remember a full-frame wrap for one edge so
  // frame_done lines up with the first output cycle of digit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc     <= '0;
      idx       <= '0;
      wrap_pend <= 1'b0;
    end else begin
      wrap_pend <= slot_end && (idx == IDX_LAST);
      if (slot_end) begin
        presc <= '0;
        idx   <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Registered display outputs, one edge behind the scan state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= 7'b0000000;
      dig        <= '0;
      frame_done <= 1'b0;
    end else begin
      seg        <= decode(cur_code);
      dig        <= sel;
      frame_done <= wrap_pend;
    end
  end

`ifdef SEG_ERR_STICKY_EN
  // Sticky error: any invalid digit sets it, and setting wins over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (any_invalid) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  // Live error: mirrors the validity of the shadow digits one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= any_invalid;
    end
  end
`endif

endmodule

// File: tb/tb_seg_2of5_scan.sv
// Testbench for seg_2of5_scan (NUM_DIGITS=4, DIV=4 plus a NUM_DIGITS=1 copy).
// Expected outputs come from a cycle-count / weight-sum model of the scanner.
module tb_seg_2of5_scan;

  localparam int ND  = 4;
  localparam int DV  = 4;
  localparam int DV1 = 3;

  localparam logic [6:0] PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011,
                                      7'b1001111, 7'b1100110, 7'b1101101,
                                      7'b1111101, 7'b0000111, 7'b1111111,
                                      7'b1101111};
  localparam logic [4:0] VALID [10] = '{5'b00110, 5'b00011, 5'b00101,
                                        5'b01001, 5'b01010, 5'b01100,
                                        5'b10001, 5'b10010, 5'b10100,
                                        5'b11000};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load = 1'b0;
  logic [5*ND-1:0] code_in = '0;
  logic            err_clr = 1'b0;
  logic [6:0]      seg;
  logic [ND-1:0]   dig;
  logic            err;
  logic            frame_done;

  logic            load1 = 1'b0;
  logic [4:0]      code_in1 = 5'b00000;
  logic            err_clr1 = 1'b0;
  logic [6:0]      seg1;
  logic [0:0]      dig1;
  logic            err1;
  logic            frame_done1;

  int passed = 0;
  int total  = 0;

  // model state
  int         n;
  logic [4:0] sh [ND];
  logic       err_m;
  logic [6:0] obs [ND];

  always #5 clk = ~clk;

  seg_2of5_scan #(.NUM_DIGITS(ND), .DIV(DV)) dut (
    .clk(clk), .rst(rst), .load(load), .code_in(code_in), .err_clr(err_clr),
    .seg(seg), .dig(dig), .err(err), .frame_done(frame_done)
  );

  seg_2of5_scan #(.NUM_DIGITS(1), .DIV(DV1)) dut1 (
    .clk(clk), .rst(rst), .load(load1), .code_in(code_in1), .err_clr(err_clr1),
    .seg(seg1), .dig(dig1), .err(err1), .frame_done(frame_done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Digit value = weight sum of the two set bits (E1..E5 = 6,3,2,1,0),
  // with 00110 reserved for zero.
  function automatic logic [6:0] model_seg(input logic [4:0] c);
    int ones, v, w;
    ones = 0;
    v = 0;
    for (int i = 0; i < 5; i++) begin
      w = (i == 0) ? 6 : (i == 1) ? 3 : (i == 2) ? 2 : (i == 3) ? 1 : 0;
      if (c[4-i]) begin
        ones++;
        v += w;
      end
    end
    if (ones != 2) return 7'b1000000;
    if (c == 5'b00110) return PAT[0];
    return PAT[v];
  endfunction

  // One clock with the inputs currently applied; model predicts, then compare.
  task automatic tick();
    int idx;
    logic [6:0] es;
    logic [ND-1:0] ed;
    logic efd, anyinv;
    idx = (n / DV) % ND;
    es  = model_seg(sh[idx]);
    ed  = ND'(1 << idx);
    efd = (n > 0) && (n % (DV * ND) == 0);
    anyinv = 1'b0;
    for (int k = 0; k < ND; k++) if (model_seg(sh[k]) == 7'b1000000) anyinv = 1'b1;
`ifdef SEG_ERR_STICKY_EN
    if (anyinv) err_m = 1'b1;
    else if (err_clr) err_m = 1'b0;
`else
    err_m = anyinv;
`endif
    if (load) for (int k = 0; k < ND; k++) sh[k] = code_in[5*k +: 5];
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(es));
    check("dig", 32'(dig), 32'(ed));
    check("err", 32'(err), 32'(err_m));
    check("frame_done", 32'(frame_done), 32'(efd));
    check("nd1_dig", 32'(dig1), 32'd1);
    check("nd1_seg", 32'(seg1), 32'(PAT[0]));
    check("nd1_frame_done", 32'(frame_done1), 32'((n > 0) && (n % DV1 == 0)));
    n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_seg", 32'(seg), 32'd0);
    check("rst_dig", 32'(dig), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_hold_dig", 32'(dig), 32'd0);
    check("rst_hold_seg", 32'(seg), 32'd0);
    rst = 1'b0;
    n = 0;
    err_m = 1'b0;
    for (int k = 0; k < ND; k++) sh[k] = 5'b00110;
  endtask

  typedef struct {
    logic [19:0] code;  // {d3,d2,d1,d0}
    logic [27:0] segs;  // {d3,d2,d1,d0}
    logic        err;
  } vec_t;

  vec_t vecs [6];
  logic [19:0] rc;
  int found;

  initial begin
    vecs[0] = '{{5'b00110, 5'b00110, 5'b00110, 5'b00110},
                {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, 1'b0};
    vecs[1] = '{{5'b11000, 5'b10001, 5'b01100, 5'b00011},
                {7'b1101111, 7'b1111101, 7'b1101101, 7'b0000110}, 1'b0};
    vecs[2] = '{{5'b01010, 5'b00111, 5'b10010, 5'b10100},
                {7'b1100110, 7'b1000000, 7'b0000111, 7'b1111111}, 1'b1};
    vecs[3] = '{{5'b01001, 5'b00101, 5'b00110, 5'b11000},
                {7'b1001111, 7'b1011011, 7'b0111111, 7'b1101111}, 1'b0};
    vecs[4] = '{{5'b00000, 5'b11111, 5'b00001, 5'b11100},
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 1'b1};
    vecs[5] = '{{5'b00011, 5'b00110, 5'b10100, 5'b10001},
                {7'b0000110, 7'b0111111, 7'b1111111, 7'b1111101}, 1'b0};

    #1;
    do_reset();

    // first frames after reset: digit 0 first, frame_done after 16 clocks
    repeat (34) tick();

    // table-driven vectors
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < ND; k++) obs[k] = 7'b0000000;
      code_in = vecs[v].code;
      load = 1'b1;
      tick();
      load = 1'b0;
      for (int c = 0; c < DV * ND + 2; c++) begin
        tick();
        for (int k = 0; k < ND; k++) if (dig == ND'(1 << k)) obs[k] = seg;
      end
      for (int k = 0; k < ND; k++) check($sformatf("vec%0d_digit%0d", v, k), 32'(obs[k]), 32'(vecs[v].segs[7*k +: 7]));
`ifndef SEG_ERR_STICKY_EN
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].err));
`endif
      $display("vector %0d code=%h seg0..3=%h %h %h %h err=%0d", v, vecs[v].code, obs[0], obs[1], obs[2], obs[3], err);
    end

`ifndef SEG_ERR_STICKY_EN
    // err latency: invalid load shows on err on the second edge only
    code_in = {5'b00011, 5'b00111, 5'b00011, 5'b00011};
    load = 1'b1;
    tick();
    load = 1'b0;
    check("err_lat1", 32'(err), 32'd0);
    tick();
    check("err_lat2", 32'(err), 32'd1);
    code_in = {5'b00011, 5'b00101, 5'b00011, 5'b00011};
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    check("err_clear_on_valid", 32'(err), 32'd0);
    $display("err latency sequence done");
`else
    // sticky: survives valid reload, cleared by err_clr, set beats clear
    do_reset();
    code_in = {5'b00011, 5'b00111, 5'b00011, 5'b00011};
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (2) tick();
    check("sticky_set", 32'(err), 32'd1);
    code_in = {5'b00011, 5'b00101, 5'b00011, 5'b00011};
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (3) tick();
    check("sticky_hold", 32'(err), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("sticky_clear", 32'(err), 32'd0);
    code_in = {5'b11111, 5'b00101, 5'b00011, 5'b00011};
    load = 1'b1;
    tick();
    load = 1'b0;
    err_clr = 1'b1;
    repeat (3) tick();
    err_clr = 1'b0;
    check("sticky_set_wins", 32'(err), 32'd1);
    $display("sticky err sequence done");
`endif

    // reset mid-slot on digit 2 aborts immediately; shadow returns to zeros
    code_in = {5'b11000, 5'b10001, 5'b01100, 5'b00011};
    load = 1'b1;
    tick();
    load = 1'b0;
    found = 0;
    for (int c = 0; c < 3 * DV * ND && found == 0; c++) begin
      tick();
      if (dig == 4'b0100) found = 1;
    end
    check("reach_digit2", 32'(found), 32'd1);
    tick();
    do_reset();
    tick();
    check("post_rst_seg", 32'(seg), 32'(PAT[0]));
    check("post_rst_dig", 32'(dig), 32'd1);
    repeat (DV * ND) tick();
    $display("mid-slot reset sequence done");

    // reset right after a frame wrap leaves no pending frame_done
    do_reset();
    repeat (DV * ND) tick();
    do_reset();
    tick();
    check("no_pending_fd", 32'(frame_done), 32'd0);
    $display("pending frame_done reset sequence done");

    // randomized loads with idle gaps
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < ND; k++) begin
        if ($urandom_range(0, 3) == 0) rc[5*k +: 5] = 5'($urandom_range(0, 31));
        else rc[5*k +: 5] = VALID[$urandom_range(0, 9)];
      end
      code_in = rc;
      err_clr = 1'($urandom_range(0, 1));
      load = 1'b1;
      tick();
      load = 1'b0;
      repeat ($urandom_range(1, 8)) begin
        err_clr = ($urandom_range(0, 3) == 0);
        tick();
      end
      $display("random txn %0d code=%h seg=%h dig=%h err=%0d", t, rc, seg, dig, err);
    end
    err_clr = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
